// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Sequences a 5-stage pipeline around the hazards that operand forwarding
//   cannot cover. It handles three cases:
//     - load-use stalls
//     - stalls behind the multi-cycle MULT/DIV unit
//     - taken-branch flushes
//   It also keeps a saturating count of stall cycles.
//
// Parameters
//   MD_LAT  cycles the MULT/DIV unit stays busy after issue (1..255)
//   CNT_W   width of Stall_Cycles
//
// Ports
//   CLOCK           in   pipeline clock, all state updates on posedge
//   RESET           in   synchronous active-high reset
//   Instruction_IN  in   instruction in ID (IF/ID register)
//   IDEX_MemRead    in   instruction in EX is a load
//   IDEX_RegD       in   destination register of the instruction in EX
//   Branch_Taken    in   branch/jump resolved taken in EX this cycle
//   PC_Write        out  PC updates this cycle
//   IFID_Write      out  IF/ID register loads this cycle
//   IFID_Flush      out  IF/ID register loads a NOP
//   IDEX_Bubble     out  ID/EX control fields zeroed
//   MD_Busy         out  MULT/DIV unit occupied
//   Stall_Cycles    out  stall cycles since reset, saturating
`timescale 1ns/1ps

module hazard_stall_controller #(
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic [31:0]      Instruction_IN,
  input  logic             IDEX_MemRead,
  input  logic [4:0]       IDEX_RegD,
  input  logic             Branch_Taken,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic             MD_Busy,
  output logic [CNT_W-1:0] Stall_Cycles
);

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  md_state_t  state, state_next;
  logic [7:0] md_cnt, md_cnt_next;

  logic [5:0] op, fn;
  logic [4:0] rs, rt;
  logic       uses_rt, load_use, md_issue, md_read, md_hazard, stall;
  logic       unused_bits;

  assign op = Instruction_IN[31:26];
  assign rs = Instruction_IN[25:21];
  assign rt = Instruction_IN[20:16];
  assign fn = Instruction_IN[5:0];

  // The rd/shamt field is irrelevant to hazard detection.
  assign unused_bits = ^Instruction_IN[15:6];

  // R-type, beq, bne and sw read rt; everything else reads rs only.
  assign uses_rt = (op == 6'h00) || (op == 6'h04) || (op == 6'h05) || (op == 6'h2B);

  assign load_use = IDEX_MemRead && (IDEX_RegD != 5'd0) &&
                    ((IDEX_RegD == rs) || (uses_rt && (IDEX_RegD == rt)));

  assign md_issue = (op == 6'h00) &&
                    ((fn == 6'h18) || (fn == 6'h19) || (fn == 6'h1A) || (fn == 6'h1B));
  assign md_read  = (op == 6'h00) && ((fn == 6'h10) || (fn == 6'h12));

  // Busy is masked during reset so it drops in the same cycle RESET rises.
  assign MD_Busy   = (state == MD_BUSY) && !RESET;
  assign md_hazard = MD_Busy && (md_issue || md_read);
  assign stall     = load_use || md_hazard;

  // Pipeline controls in priority order reset > branch > stall > run,
  // plus the MULT/DIV occupancy FSM.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    state_next  = state;
    md_cnt_next = md_cnt;

    if (RESET) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (Branch_Taken) begin
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
    end else if (stall) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end

    // The unit is claimed only when the MULT/DIV op actually leaves ID.
    // A branch in MD_BUSY does not touch the count because that op is
    // already past EX.
    case (state)
      IDLE: begin
        if (md_issue && !stall && !Branch_Taken) begin
          state_next  = MD_BUSY;
          md_cnt_next = MD_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt != 8'd0) begin
          md_cnt_next = md_cnt - 8'd1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state        <= IDLE;
      md_cnt       <= 8'd0;
      Stall_Cycles <= '0;
    end else begin
      state  <= state_next;
      md_cnt <= md_cnt_next;
      if (!Branch_Taken && stall && (Stall_Cycles != {CNT_W{1'b1}})) begin
        Stall_Cycles <= Stall_Cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller
//   Directed checks of hazard_stall_controller.
//   dut     : MD_LAT=8, CNT_W=16
//   dut_sat : MD_LAT=8, CNT_W=4, shares all stimulus, used for saturation
`timescale 1ns/1ps

module tb_hazard_stall_controller;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] ADD   = 32'h010A_4820; // add  $9,$8,$10
  localparam logic [31:0] ADD0  = 32'h0000_4820; // add  $9,$0,$0
  localparam logic [31:0] LW    = 32'h8D09_0000; // lw   $9,0($8)
  localparam logic [31:0] MULT  = 32'h0109_0018; // mult $8,$9
  localparam logic [31:0] MFLO  = 32'h0000_5012; // mflo $10

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic [31:0] Instruction_IN;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_RegD;
  logic        Branch_Taken;

  logic        pc_write, ifid_write, ifid_flush, idex_bubble, md_busy;
  logic [15:0] stall_cycles;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_md_busy;
  logic [3:0]  s_stall_cycles;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 CLOCK = ~CLOCK;

  hazard_stall_controller #(.MD_LAT(8), .CNT_W(16)) dut (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .Instruction_IN (Instruction_IN),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_RegD      (IDEX_RegD),
    .Branch_Taken   (Branch_Taken),
    .PC_Write       (pc_write),
    .IFID_Write     (ifid_write),
    .IFID_Flush     (ifid_flush),
    .IDEX_Bubble    (idex_bubble),
    .MD_Busy        (md_busy),
    .Stall_Cycles   (stall_cycles)
  );

  hazard_stall_controller #(.MD_LAT(8), .CNT_W(4)) dut_sat (
    .CLOCK          (CLOCK),
    .RESET          (RESET),
    .Instruction_IN (Instruction_IN),
    .IDEX_MemRead   (IDEX_MemRead),
    .IDEX_RegD      (IDEX_RegD),
    .Branch_Taken   (Branch_Taken),
    .PC_Write       (s_pc_write),
    .IFID_Write     (s_ifid_write),
    .IFID_Flush     (s_ifid_flush),
    .IDEX_Bubble    (s_idex_bubble),
    .MD_Busy        (s_md_busy),
    .Stall_Cycles   (s_stall_cycles)
  );

  // Drive one cycle of inputs at the falling edge and let combinational
  // outputs settle before any check.
  task automatic applyStimulus(input logic rst, input logic [31:0] instr,
                               input logic mem_read, input logic [4:0] reg_d,
                               input logic branch);
    @(negedge CLOCK);
    RESET          = rst;
    Instruction_IN = instr;
    IDEX_MemRead   = mem_read;
    IDEX_RegD      = reg_d;
    Branch_Taken   = branch;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkControls(input string tag, input logic pc, input logic ifid,
                               input logic flush, input logic bubble);
    checkOutput({tag, " PC_Write"},    {31'd0, pc_write},    {31'd0, pc});
    checkOutput({tag, " IFID_Write"},  {31'd0, ifid_write},  {31'd0, ifid});
    checkOutput({tag, " IFID_Flush"},  {31'd0, ifid_flush},  {31'd0, flush});
    checkOutput({tag, " IDEX_Bubble"}, {31'd0, idex_bubble}, {31'd0, bubble});
  endtask

  initial begin
    RESET          = 1'b1;
    Instruction_IN = NOP;
    IDEX_MemRead   = 1'b0;
    IDEX_RegD      = 5'd0;
    Branch_Taken   = 1'b0;

    // Reset behaviour
    applyStimulus(1'b1, NOP, 1'b0, 5'd0, 1'b0);
    checkControls("reset", 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset MD_Busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(1'b1, NOP, 1'b0, 5'd0, 1'b0);
    checkOutput("reset Stall_Cycles", {16'd0, stall_cycles}, 32'd0);
    checkOutput("reset sat Stall_Cycles", {28'd0, s_stall_cycles}, 32'd0);

    applyStimulus(1'b0, NOP, 1'b0, 5'd0, 1'b0);
    checkControls("run", 1'b1, 1'b1, 1'b0, 1'b0);

    // T1: load-use on rs, then on rt
    applyStimulus(1'b0, ADD, 1'b1, 5'd8, 1'b0);
    checkControls("load-use rs", 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("load-use count before", {16'd0, stall_cycles}, 32'd0);
    applyStimulus(1'b0, NOP, 1'b0, 5'd0, 1'b0);
    checkOutput("load-use count after", {16'd0, stall_cycles}, 32'd1);
    checkControls("load-use cleared", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, ADD, 1'b1, 5'd10, 1'b0);
    checkControls("load-use rt", 1'b0, 1'b0, 1'b0, 1'b1);

    // T2: no false stalls
    applyStimulus(1'b0, ADD0, 1'b1, 5'd0, 1'b0);
    checkControls("reg0 no stall", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, LW, 1'b1, 5'd9, 1'b0);
    checkControls("lw rt no stall", 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, ADD, 1'b0, 5'd8, 1'b0);
    checkControls("no memread no stall", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("count after T2", {16'd0, stall_cycles}, 32'd2);

    // T4: branch beats load-use, no stall counted
    applyStimulus(1'b0, ADD, 1'b1, 5'd8, 1'b1);
    checkControls("branch priority", 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b0, NOP, 1'b0, 5'd0, 1'b0);
    checkOutput("branch count unchanged", {16'd0, stall_cycles}, 32'd2);

    // T3: mult then mflo stalled for the 8 busy cycles
    applyStimulus(1'b0, MULT, 1'b0, 5'd0, 1'b0);
    checkControls("mult issue", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("mult issue MD_Busy", {31'd0, md_busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, MFLO, 1'b0, 5'd0, 1'b0);
      checkOutput($sformatf("md busy cycle %0d", i + 1), {31'd0, md_busy}, 32'd1);
      checkControls($sformatf("mflo stall %0d", i + 1), 1'b0, 1'b0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, MFLO, 1'b0, 5'd0, 1'b0);
    checkOutput("md done MD_Busy", {31'd0, md_busy}, 32'd0);
    checkControls("mflo issues", 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("count after T3", {16'd0, stall_cycles}, 32'd10);

    // T5: reset at busy cycle 3
    applyStimulus(1'b0, MULT, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, MFLO, 1'b0, 5'd0, 1'b0);
    checkOutput("T5 busy cycle 1", {31'd0, md_busy}, 32'd1);
    applyStimulus(1'b0, MFLO, 1'b0, 5'd0, 1'b0);
    checkOutput("T5 busy cycle 2", {31'd0, md_busy}, 32'd1);
    checkOutput("T5 count before reset", {16'd0, stall_cycles}, 32'd11);
    applyStimulus(1'b1, MFLO, 1'b0, 5'd0, 1'b0);
    checkControls("T5 reset", 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("T5 reset MD_Busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(1'b0, MFLO, 1'b0, 5'd0, 1'b0);
    checkOutput("T5 after MD_Busy", {31'd0, md_busy}, 32'd0);
    checkOutput("T5 after Stall_Cycles", {16'd0, stall_cycles}, 32'd0);
    checkControls("T5 mflo free", 1'b1, 1'b1, 1'b0, 1'b0);

    // T6: saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, ADD, 1'b1, 5'd8, 1'b0);
    end
    applyStimulus(1'b0, NOP, 1'b0, 5'd0, 1'b0);
    checkOutput("sat Stall_Cycles 20", {28'd0, s_stall_cycles}, 32'd15);
    checkOutput("wide Stall_Cycles 20", {16'd0, stall_cycles}, 32'd20);
    applyStimulus(1'b0, ADD, 1'b1, 5'd8, 1'b0);
    checkOutput("sat stall outputs", {31'd0, s_idex_bubble}, 32'd1);
    applyStimulus(1'b0, NOP, 1'b0, 5'd0, 1'b0);
    checkOutput("sat Stall_Cycles held", {28'd0, s_stall_cycles}, 32'd15);
    checkOutput("wide Stall_Cycles 21", {16'd0, stall_cycles}, 32'd21);
    checkOutput("sat PC_Write", {31'd0, s_pc_write}, 32'd1);
    checkOutput("sat IFID_Write", {31'd0, s_ifid_write}, 32'd1);
    checkOutput("sat IFID_Flush", {31'd0, s_ifid_flush}, 32'd0);
    checkOutput("sat MD_Busy", {31'd0, s_md_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
